// File: rtl/seq_mult_ctrl_if.sv
// Handshake and datapath-enable bundle between the multiplier controller (slave)
// and its upstream master plus the enable-gated datapath.
interface seq_mult_ctrl_if #(
    parameter int unsigned COUNT_WIDTH = 3
);
    logic                   start;
    logic                   multiplier_lsb;
    logic                   load_en;
    logic                   acc_clear;
    logic                   add_en;
    logic                   shift_en;
    logic                   product_en;
    logic                   ready;
    logic                   busy;
    logic                   done;
    logic [COUNT_WIDTH-1:0] step_count;

    modport slave (
        input  start, multiplier_lsb,
        output load_en, acc_clear, add_en, shift_en, product_en,
        output ready, busy, done, step_count
    );

    modport master (
        output start, multiplier_lsb,
        input  load_en, acc_clear, add_en, shift_en, product_en,
        input  ready, busy, done, step_count
    );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Control FSM for a shift-and-add sequential multiplier: sequences load, add,
// shift and product capture of an external datapath, one multiply at a time.
module seq_mult_ctrl #(
    parameter int unsigned WORD_LENGTH = 4,
    parameter int unsigned COUNT_WIDTH = 3
) (
    input  logic              clk,
    input  logic              reset,
    seq_mult_ctrl_if.slave    bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] EVAL  = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    // Compared at counter width so the last step is detected before any wrap.
    localparam logic [COUNT_WIDTH-1:0] LAST_STEP = COUNT_WIDTH'(WORD_LENGTH - 1);

    logic [2:0]             state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = LOAD;
            end
            LOAD: begin
                count_d = '0;
                state_d = EVAL;
            end
            EVAL: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                if (count_q == LAST_STEP) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                    state_d = EVAL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Moore decode; add_en alone also follows the multiplier LSB.
    always_comb begin
        bus.load_en    = (state_q == LOAD);
        bus.acc_clear  = (state_q == LOAD);
        bus.add_en     = (state_q == EVAL) && bus.multiplier_lsb;
        bus.shift_en   = (state_q == SHIFT);
        bus.product_en = (state_q == DONE);
        bus.done       = (state_q == DONE);
        bus.ready      = (state_q == IDLE);
        bus.busy       = (state_q != IDLE);
        bus.step_count = count_q;
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl with a small shift-and-add datapath model
// driven by the controller's enables.
module tb_seq_mult_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seq_mult_ctrl_if #(.COUNT_WIDTH(3)) bus ();

    seq_mult_ctrl #(.WORD_LENGTH(4), .COUNT_WIDTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [3:0] op_a, op_b;
    logic [7:0] mcand, acc, product;
    logic [3:0] mplier;

    assign bus.multiplier_lsb = mplier[0];

    always @(posedge clk) begin
        if (bus.load_en) begin
            mcand  <= {4'b0000, op_a};
            mplier <= op_b;
        end
        if (bus.acc_clear) acc <= 8'd0;
        else if (bus.add_en) acc <= acc + mcand;
        if (bus.shift_en) begin
            mplier <= mplier >> 1;
            mcand  <= mcand << 1;
        end
        if (bus.product_en) product <= acc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mult(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic [7:0] exp_p, input bit poke);
        op_a = a;
        op_b = b;
        check({tag, ".ready_pre"}, 32'(bus.ready), 32'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, ".load"}, 32'(bus.load_en), 32'd1);
        check({tag, ".clr"}, 32'(bus.acc_clear), 32'd1);
        check({tag, ".busy"}, 32'(bus.busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus.start = poke;
            tick();
            check($sformatf("%s.eval%0d_add", tag, i), 32'(bus.add_en), 32'(b[i]));
            check($sformatf("%s.eval%0d_cnt", tag, i), 32'(bus.step_count), 32'(i));
            check($sformatf("%s.eval%0d_ld", tag, i), 32'(bus.load_en), 32'd0);
            tick();
            check($sformatf("%s.shift%0d", tag, i), 32'(bus.shift_en), 32'd1);
            check($sformatf("%s.shift%0d_add", tag, i), 32'(bus.add_en), 32'd0);
            check($sformatf("%s.shift%0d_ld", tag, i), 32'(bus.load_en), 32'd0);
        end
        bus.start = 1'b0;
        tick();
        check({tag, ".done"}, 32'(bus.done), 32'd1);
        check({tag, ".prod_en"}, 32'(bus.product_en), 32'd1);
        tick();
        check({tag, ".ready_post"}, 32'(bus.ready), 32'd1);
        check({tag, ".done_low"}, 32'(bus.done), 32'd0);
        check({tag, ".cnt_hold"}, 32'(bus.step_count), 32'd3);
        check({tag, ".product"}, 32'(product), 32'(exp_p));
    endtask

    logic ld_h[1:30];
    logic dn_h[1:30];
    logic rd_h[1:30];

    initial begin
        int loads, dones, seen;
        bus.start = 1'b0;
        op_a = 4'd0;
        op_b = 4'd0;

        // Reset held, then released
        repeat (3) tick();
        check("rst_held.ready", 32'(bus.ready), 32'd1);
        reset = 1'b0;
        tick();
        check("rst.ready", 32'(bus.ready), 32'd1);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.enables", 32'({bus.load_en, bus.acc_clear, bus.add_en, bus.shift_en,
                                  bus.product_en, bus.done}), 32'd0);
        check("rst.cnt", 32'(bus.step_count), 32'd0);

        // 11 * 13 = 143, lsb sequence 1,0,1,1
        run_mult("m11x13", 4'd11, 4'd13, 8'd143, 1'b0);
        tick();

        // start pokes while busy are ignored
        run_mult("poke", 4'd7, 4'd6, 8'd42, 1'b1);
        tick();
        check("poke.no_relaunch", 32'(bus.ready), 32'd1);

        // x * 0: no adds, same timing
        run_mult("m9x0", 4'd9, 4'd0, 8'd0, 1'b0);
        tick();

        // start held high: back-to-back with one IDLE cycle between
        op_a = 4'd3;
        op_b = 4'd5;
        bus.start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            ld_h[c] = bus.load_en;
            dn_h[c] = bus.done;
            rd_h[c] = bus.ready;
        end
        bus.start = 1'b0;
        loads = 0;
        dones = 0;
        for (int c = 1; c <= 30; c++) begin
            if (ld_h[c]) loads++;
            if (dn_h[c]) begin
                dones++;
                if (c <= 28) begin
                    check($sformatf("hold.idle_after_done%0d", c), 32'(rd_h[c+1]), 32'd1);
                    check($sformatf("hold.load_after_idle%0d", c), 32'(ld_h[c+2]), 32'd1);
                end
            end
        end
        check("hold.loads", 32'(loads), 32'd3);
        check("hold.dones", 32'(dones), 32'd2);
        check("hold.product", 32'(product), 32'd15);
        seen = 0;
        for (int c = 0; c < 20 && !bus.ready; c++) tick();
        check("hold.drain_ready", 32'(bus.ready), 32'd1);
        tick();

        // reset during the third SHIFT
        op_a = 4'd15;
        op_b = 4'd15;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        check("arst.in_shift2", 32'(bus.shift_en), 32'd1);
        check("arst.cnt2", 32'(bus.step_count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("arst.ready", 32'(bus.ready), 32'd1);
        check("arst.busy", 32'(bus.busy), 32'd0);
        check("arst.shift", 32'(bus.shift_en), 32'd0);
        check("arst.cnt", 32'(bus.step_count), 32'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.done || bus.product_en) seen++;
        end
        check("arst.no_done", 32'(seen), 32'd0);
        run_mult("m5x7", 4'd5, 4'd7, 8'd35, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
